m_pkt_commit_buf: RTL

M_PKT_COMMIT_BUF -- requirements
Module: m_pkt_commit_buf

---
 rtl/m_pkt_commit_buf.sv | 88 ++++++++
 1 files changed

// File: rtl/m_pkt_commit_buf.sv
// m_pkt_commit_buf: store-and-forward packet buffer exposing only committed packets downstream
module m_pkt_commit_buf #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 64,
  parameter int LEN_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_vld,
  input  logic              in_sop,
  input  logic              in_eop,
  input  logic [LEN_W-1:0]  in_length,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_buffer,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic              out_sop,
  output logic              out_eop,
  output logic [LEN_W-1:0]  out_length,
  output logic [DATA_W-1:0] out_data,
  output logic [15:0]       drop_cnt,
  output logic [15:0]       ovf_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = DATA_W + LEN_W + 2;
  typedef enum logic [1:0] {IDLE, IN_PKT, DROP} state_t;
  state_t state, nxt_state;
  logic [PW-1:0] wr_ptr, cmt_ptr, rd_ptr, nxt_wr, nxt_cmt, base;
  logic [EW-1:0] mem [DEPTH];
  logic sop_w, mid_w, restart, full_b, we, drop_inc;
  logic [1:0] ovf_add;
  function automatic logic [15:0] sat(input logic [15:0] c, input logic [1:0] a);
    logic [16:0] s;
    s = {1'b0, c} + {15'b0, a};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction
  assign sop_w   = in_vld & in_sop;
  assign mid_w   = in_vld & ~in_sop;
  assign restart = (state == IN_PKT) & sop_w;
  // a sop that abandons a partial packet writes over it, so fullness is judged from cmt_ptr
  assign base    = restart ? cmt_ptr : wr_ptr;
  assign full_b  = (base - rd_ptr) == PW'(DEPTH);
  always_comb begin
    nxt_state = state;
    nxt_wr    = restart ? cmt_ptr : wr_ptr;
    nxt_cmt   = cmt_ptr;
    we        = 1'b0;
    drop_inc  = 1'b0;
    ovf_add   = {1'b0, restart};
    if (sop_w || (mid_w && state == IN_PKT)) begin
      if (!full_b) begin
        we        = 1'b1;
        nxt_wr    = base + 1'b1;
        nxt_state = in_eop ? IDLE : IN_PKT;
        if (in_eop && in_buffer) nxt_cmt = base + 1'b1;
        else if (in_eop) begin
          nxt_wr   = cmt_ptr;
          drop_inc = 1'b1;
        end
      end else begin
        nxt_state = in_eop ? IDLE : DROP;
        nxt_wr    = cmt_ptr;
        ovf_add   = ovf_add + (sop_w ? {1'b0, in_eop} : 2'd1);
      end
    end else if (mid_w && state == DROP && in_eop) nxt_state = IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      cmt_ptr  <= '0;
      rd_ptr   <= '0;
      drop_cnt <= '0;
      ovf_cnt  <= '0;
    end else begin
      state    <= nxt_state;
      wr_ptr   <= nxt_wr;
      cmt_ptr  <= nxt_cmt;
      rd_ptr   <= rd_ptr + PW'(out_vld & out_rdy);
      drop_cnt <= sat(drop_cnt, {1'b0, drop_inc});
      ovf_cnt  <= sat(ovf_cnt, ovf_add);
    end
  end
  always_ff @(posedge clk) if (we) mem[base[AW-1:0]] <= {in_sop, in_eop, in_length, in_data};
  assign out_vld = rd_ptr != cmt_ptr;
  assign {out_sop, out_eop, out_length, out_data} = mem[rd_ptr[AW-1:0]];
endmodule
